// File: rtl/reorder_buffer.sv
// In-order retirement buffer: one allocation per cycle, two completion lanes, and up to two
// in-order retirements per cycle that return the rd's previous tag to the rename free pool.
module reorder_buffer #(
    parameter int unsigned NUM_TAGS      = 64,
    parameter int unsigned NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
    parameter int unsigned ROB_DEPTH     = 16,
    parameter int unsigned ROB_IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    input  logic                     alloc_has_rd,
    input  logic [NUM_TAGS_LOG2-1:0] alloc_tag_old,
    output logic                     alloc_ready,
    output logic [ROB_IDX_W-1:0]     alloc_idx,
    input  logic [1:0]               complete_valid,
    input  logic [ROB_IDX_W-1:0]     complete_idx [0:1],
    output logic [NUM_TAGS_LOG2-1:0] retire_tag   [0:1],
    output logic [1:0]               retire_valid,
    output logic [ROB_IDX_W:0]       rob_count,
    output logic                     rob_empty
);

    // Pointers carry one extra wrap bit above the entry index.
    typedef logic [ROB_IDX_W:0] ptr_t;
    localparam ptr_t DepthCnt = ptr_t'(ROB_DEPTH);

    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    ptr_t count_q, count_d;

    logic [ROB_DEPTH-1:0]     valid_q, valid_d;
    logic [ROB_DEPTH-1:0]     done_q, done_d;
    logic [ROB_DEPTH-1:0]     has_rd_q;
    logic [NUM_TAGS_LOG2-1:0] tag_old_q [ROB_DEPTH];

    logic [ROB_IDX_W-1:0] head_idx;
    logic [ROB_IDX_W-1:0] tail_idx;
    logic [ROB_IDX_W-1:0] slot_idx [2];
    logic [1:0]           retire_ok;
    logic [1:0]           retire_cnt;
    logic                 alloc_fire;

    assign head_idx    = head_q[ROB_IDX_W-1:0];
    assign tail_idx    = tail_q[ROB_IDX_W-1:0];
    assign slot_idx[0] = head_idx;
    assign slot_idx[1] = head_idx + 1'b1;

    assign alloc_ready = (count_q < DepthCnt);
    assign alloc_idx   = tail_idx;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign rob_count   = count_q;
    assign rob_empty   = (count_q == '0);

    // Slot 1 may only retire behind slot 0, which keeps retirement in program order.
    assign retire_ok[0] = valid_q[slot_idx[0]] & done_q[slot_idx[0]];
    assign retire_ok[1] = retire_ok[0] & valid_q[slot_idx[1]] & done_q[slot_idx[1]];
    assign retire_cnt   = {1'b0, retire_ok[0]} + {1'b0, retire_ok[1]};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            retire_valid[i] = retire_ok[i] & has_rd_q[slot_idx[i]]
                            & (tag_old_q[slot_idx[i]] != '0);
            retire_tag[i]   = retire_valid[i] ? tag_old_q[slot_idx[i]] : '0;
        end
    end

    always_comb begin
        head_d  = head_q + ptr_t'(retire_cnt);
        tail_d  = tail_q + ptr_t'(alloc_fire);
        count_d = count_q + ptr_t'(alloc_fire) - ptr_t'(retire_cnt);
    end

    // Completions only mark live entries; retire then alloc override them per slot.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        for (int l = 0; l < 2; l++) begin
            if (complete_valid[l] && valid_q[complete_idx[l]]) begin
                done_d[complete_idx[l]] = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (retire_ok[i]) begin
                valid_d[slot_idx[i]] = 1'b0;
                done_d[slot_idx[i]]  = 1'b0;
            end
        end
        if (alloc_fire) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_rd_q[tail_idx]  <= alloc_has_rd;
            tag_old_q[tail_idx] <= alloc_tag_old;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against a program-order queue model.
module tb_reorder_buffer;

    localparam int Depth = 16;
    localparam int TagW  = 6;
    localparam int IdxW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            alloc_valid;
    logic            alloc_has_rd;
    logic [TagW-1:0] alloc_tag_old;
    logic            alloc_ready;
    logic [IdxW-1:0] alloc_idx;
    logic [1:0]      complete_valid;
    logic [IdxW-1:0] complete_idx [0:1];
    logic [TagW-1:0] retire_tag   [0:1];
    logic [1:0]      retire_valid;
    logic [IdxW:0]   rob_count;
    logic            rob_empty;

    reorder_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_has_rd   (alloc_has_rd),
        .alloc_tag_old  (alloc_tag_old),
        .alloc_ready    (alloc_ready),
        .alloc_idx      (alloc_idx),
        .complete_valid (complete_valid),
        .complete_idx   (complete_idx),
        .retire_tag     (retire_tag),
        .retire_valid   (retire_valid),
        .rob_count      (rob_count),
        .rob_empty      (rob_empty)
    );

    always #5 clk = ~clk;

    // Model: instructions in program order; mq[0] is the oldest, living at entry m_head.
    typedef struct {
        bit has_rd;
        int tag;
        bit done;
    } ent_t;

    ent_t mq[$];
    int   m_head;
    int   vectors;
    int   miscompares;

    function automatic int exp_count();
        return mq.size();
    endfunction

    function automatic bit exp_slot(input int s);
        if (mq.size() <= s) return 1'b0;
        if (!mq[0].done) return 1'b0;
        if (s == 1 && !mq[1].done) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_rv(input int s);
        if (!exp_slot(s)) return 1'b0;
        return mq[s].has_rd && (mq[s].tag != 0);
    endfunction

    function automatic int exp_rtag(input int s);
        if (!exp_rv(s)) return 0;
        return mq[s].tag;
    endfunction

    task automatic drive_cycle(input bit r, input bit av, input bit hr, input int tag,
                               input bit [1:0] cv, input int c0, input int c1);
        int   n;
        int   sz;
        int   off;
        int   ci;
        bit   rdy;
        ent_t e;
        @(negedge clk);
        rst             = r;
        alloc_valid     = av;
        alloc_has_rd    = hr;
        alloc_tag_old   = TagW'(tag);
        complete_valid  = cv;
        complete_idx[0] = IdxW'(c0);
        complete_idx[1] = IdxW'(c1);
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_head = 0;
        end else begin
            sz  = mq.size();
            rdy = sz < Depth;
            n   = 0;
            if (sz >= 1 && mq[0].done) n = 1;
            if (n == 1 && sz >= 2 && mq[1].done) n = 2;
            for (int l = 0; l < 2; l++) begin
                if (cv[l]) begin
                    ci  = (l == 0) ? c0 : c1;
                    off = (ci - m_head + Depth) % Depth;
                    if (off < sz) begin
                        e      = mq[off];
                        e.done = 1'b1;
                        mq[off] = e;
                    end
                end
            end
            repeat (n) void'(mq.pop_front());
            m_head = (m_head + n) % Depth;
            if (av && rdy) begin
                e.has_rd = hr;
                e.tag    = tag;
                e.done   = 1'b0;
                mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b00, 0, 0);
    endtask

    task automatic do_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 0, 2'b00, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        vectors++;
        if (rob_count !== 5'd0) begin
            $display("FAIL reset_count: got %0d want 0", rob_count); miscompares++;
        end
        vectors++;
        if (alloc_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b want 1", alloc_ready); miscompares++;
        end
        vectors++;
        if (alloc_idx !== 4'd0) begin
            $display("FAIL reset_idx: got %0d want 0", alloc_idx); miscompares++;
        end
        vectors++;
        if (rob_empty !== 1'b1) begin
            $display("FAIL reset_empty: got %b want 1", rob_empty); miscompares++;
        end
        vectors++;
        if (retire_valid !== 2'b00 || retire_tag[0] !== 6'd0 || retire_tag[1] !== 6'd0) begin
            $display("FAIL reset_retire: got rv=%b tags=%0d,%0d want 00,0,0",
                     retire_valid, retire_tag[0], retire_tag[1]);
            miscompares++;
        end
    endtask

    task automatic test_in_order_pair();
        do_reset();
        drive_cycle(1'b0, 1'b1, 1'b1, 40, 2'b00, 0, 0);
        drive_cycle(1'b0, 1'b1, 1'b1, 41, 2'b00, 0, 0);
        vectors++;
        if (alloc_idx !== 4'd2) begin
            $display("FAIL pair_alloc_idx: got %0d want 2", alloc_idx); miscompares++;
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b01, 1, 0);
        vectors++;
        if (retire_valid !== 2'b00) begin
            $display("FAIL pair_no_early_retire: got %b want 00", retire_valid); miscompares++;
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b01, 0, 0);
        vectors++;
        if (retire_valid !== 2'b11 || retire_tag[0] !== 6'd40 || retire_tag[1] !== 6'd41) begin
            $display("FAIL pair_retire: got rv=%b tags=%0d,%0d want 11,40,41",
                     retire_valid, retire_tag[0], retire_tag[1]);
            miscompares++;
        end
        idle();
        vectors++;
        if (rob_count !== 5'd0 || retire_valid !== 2'b00) begin
            $display("FAIL pair_drained: got count=%0d rv=%b want 0,00", rob_count, retire_valid);
            miscompares++;
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < Depth; i++) drive_cycle(1'b0, 1'b1, 1'b1, i + 1, 2'b00, 0, 0);
        vectors++;
        if (alloc_ready !== 1'b0 || rob_count !== 5'd16) begin
            $display("FAIL full_state: got ready=%b count=%0d want 0,16", alloc_ready, rob_count);
            miscompares++;
        end
        drive_cycle(1'b0, 1'b1, 1'b1, 50, 2'b00, 0, 0);
        vectors++;
        if (rob_count !== 5'd16 || alloc_idx !== 4'd0) begin
            $display("FAIL full_ignore: got count=%0d idx=%0d want 16,0", rob_count, alloc_idx);
            miscompares++;
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b01, 0, 0);
        vectors++;
        if (retire_valid !== 2'b01 || retire_tag[0] !== 6'd1 || alloc_ready !== 1'b0) begin
            $display("FAIL full_retire: got rv=%b tag=%0d ready=%b want 01,1,0",
                     retire_valid, retire_tag[0], alloc_ready);
            miscompares++;
        end
        drive_cycle(1'b0, 1'b1, 1'b1, 33, 2'b00, 0, 0);
        vectors++;
        if (rob_count !== 5'd15 || alloc_ready !== 1'b1 || alloc_idx !== 4'd0) begin
            $display("FAIL full_after_retire: got count=%0d ready=%b idx=%0d want 15,1,0",
                     rob_count, alloc_ready, alloc_idx);
            miscompares++;
        end
        drive_cycle(1'b0, 1'b1, 1'b1, 33, 2'b00, 0, 0);
        vectors++;
        if (rob_count !== 5'd16 || alloc_idx !== 4'd1 || alloc_ready !== 1'b0) begin
            $display("FAIL full_realloc: got count=%0d idx=%0d ready=%b want 16,1,0",
                     rob_count, alloc_idx, alloc_ready);
            miscompares++;
        end
    endtask

    task automatic test_no_rd();
        do_reset();
        drive_cycle(1'b0, 1'b1, 1'b0, 7, 2'b00, 0, 0);
        drive_cycle(1'b0, 1'b1, 1'b1, 0, 2'b00, 0, 0);
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b11, 0, 1);
        vectors++;
        if (retire_valid !== 2'b00 || retire_tag[0] !== 6'd0 || retire_tag[1] !== 6'd0) begin
            $display("FAIL nord_retire: got rv=%b tags=%0d,%0d want 00,0,0",
                     retire_valid, retire_tag[0], retire_tag[1]);
            miscompares++;
        end
        idle();
        vectors++;
        if (rob_count !== 5'd0 || alloc_idx !== 4'd2 || rob_empty !== 1'b1) begin
            $display("FAIL nord_head: got count=%0d idx=%0d empty=%b want 0,2,1",
                     rob_count, alloc_idx, rob_empty);
            miscompares++;
        end
    endtask

    task automatic test_wrap();
        int k;
        do_reset();
        for (int i = 0; i < Depth - 1; i++) drive_cycle(1'b0, 1'b1, 1'b1, i + 1, 2'b00, 0, 0);
        for (int i = 0; i < Depth - 1; i += 2) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 0, (i + 1 < Depth - 1) ? 2'b11 : 2'b01, i, i + 1);
        end
        k = 0;
        while (k < 20 && rob_count != 0) begin
            idle();
            k++;
        end
        vectors++;
        if (rob_count != 0) begin
            $display("FAIL wrap_drain_timeout: got count=%0d want 0", rob_count); miscompares++;
        end
        vectors++;
        if (alloc_idx !== 4'd15) begin
            $display("FAIL wrap_tail: got %0d want 15", alloc_idx); miscompares++;
        end
        drive_cycle(1'b0, 1'b1, 1'b1, 20, 2'b00, 0, 0);
        drive_cycle(1'b0, 1'b1, 1'b1, 21, 2'b00, 0, 0);
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b11, 15, 0);
        vectors++;
        if (retire_valid !== 2'b11 || retire_tag[0] !== 6'd20 || retire_tag[1] !== 6'd21) begin
            $display("FAIL wrap_retire: got rv=%b tags=%0d,%0d want 11,20,21",
                     retire_valid, retire_tag[0], retire_tag[1]);
            miscompares++;
        end
        idle();
        vectors++;
        if (rob_count !== 5'd0 || alloc_idx !== 4'd1) begin
            $display("FAIL wrap_head: got count=%0d idx=%0d want 0,1", rob_count, alloc_idx);
            miscompares++;
        end
    endtask

    task automatic test_dup_complete();
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 1'b1, 10 + i, 2'b00, 0, 0);
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b11, 3, 3);
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b01, 5, 0);
        vectors++;
        if (rob_count !== 5'd4 || retire_valid !== 2'b00) begin
            $display("FAIL dup_hold: got count=%0d rv=%b want 4,00", rob_count, retire_valid);
            miscompares++;
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b11, 0, 1);
        vectors++;
        if (retire_valid !== 2'b11 || retire_tag[0] !== 6'd10 || retire_tag[1] !== 6'd11) begin
            $display("FAIL dup_first_pair: got rv=%b tags=%0d,%0d want 11,10,11",
                     retire_valid, retire_tag[0], retire_tag[1]);
            miscompares++;
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b01, 2, 0);
        vectors++;
        if (retire_valid !== 2'b11 || retire_tag[0] !== 6'd12 || retire_tag[1] !== 6'd13) begin
            $display("FAIL dup_second_pair: got rv=%b tags=%0d,%0d want 11,12,13",
                     retire_valid, retire_tag[0], retire_tag[1]);
            miscompares++;
        end
        drive_cycle(1'b0, 1'b1, 1'b1, 14, 2'b00, 0, 0);
        drive_cycle(1'b0, 1'b1, 1'b1, 15, 2'b00, 0, 0);
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b01, 4, 0);
        vectors++;
        if (retire_valid !== 2'b01 || retire_tag[0] !== 6'd14 || retire_tag[1] !== 6'd0) begin
            $display("FAIL dup_invalid_ignored: got rv=%b tags=%0d,%0d want 01,14,0",
                     retire_valid, retire_tag[0], retire_tag[1]);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b1, 1'b1, i + 1, 2'b00, 0, 0);
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b11, 1, 2);
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b11, 3, 4);
        drive_cycle(1'b0, 1'b0, 1'b0, 0, 2'b01, 5, 0);
        vectors++;
        if (rob_count !== 5'd6 || retire_valid !== 2'b00) begin
            $display("FAIL rstmid_pending: got count=%0d rv=%b want 6,00", rob_count, retire_valid);
            miscompares++;
        end
        drive_cycle(1'b1, 1'b1, 1'b1, 9, 2'b01, 0, 0);
        vectors++;
        if (rob_count !== 5'd0 || retire_valid !== 2'b00 || alloc_idx !== 4'd0
            || rob_empty !== 1'b1) begin
            $display("FAIL rstmid_clear: got count=%0d rv=%b idx=%0d empty=%b want 0,00,0,1",
                     rob_count, retire_valid, alloc_idx, rob_empty);
            miscompares++;
        end
        idle();
        vectors++;
        if (rob_count !== 5'd0 || retire_valid !== 2'b00) begin
            $display("FAIL rstmid_after: got count=%0d rv=%b want 0,00", rob_count, retire_valid);
            miscompares++;
        end
    endtask

    task automatic test_random();
        bit       r;
        bit       av;
        bit       hr;
        bit [1:0] cv;
        int       c [2];
        do_reset();
        for (int n = 0; n < 500; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            av = ($urandom_range(0, 99) < 65);
            hr = 1'($urandom_range(0, 1));
            cv = 2'($urandom_range(0, 3));
            for (int l = 0; l < 2; l++) begin
                if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                    c[l] = (m_head + $urandom_range(0, mq.size() - 1)) % Depth;
                end else begin
                    c[l] = $urandom_range(0, Depth - 1);
                end
            end
            drive_cycle(r, av, hr, $urandom_range(0, 63), cv, c[0], c[1]);
            vectors++;
            if (int'(rob_count) !== exp_count()) begin
                $display("FAIL rand_count[%0d]: got %0d want %0d", n, rob_count, exp_count());
                miscompares++;
            end
            vectors++;
            if (alloc_ready !== (exp_count() < Depth)) begin
                $display("FAIL rand_ready[%0d]: got %b want %b", n, alloc_ready,
                         exp_count() < Depth);
                miscompares++;
            end
            vectors++;
            if (int'(alloc_idx) !== (m_head + exp_count()) % Depth) begin
                $display("FAIL rand_alloc_idx[%0d]: got %0d want %0d", n, alloc_idx,
                         (m_head + exp_count()) % Depth);
                miscompares++;
            end
            vectors++;
            if (rob_empty !== (exp_count() == 0)) begin
                $display("FAIL rand_empty[%0d]: got %b want %b", n, rob_empty, exp_count() == 0);
                miscompares++;
            end
            for (int s = 0; s < 2; s++) begin
                vectors++;
                if (retire_valid[s] !== exp_rv(s) || int'(retire_tag[s]) !== exp_rtag(s)) begin
                    $display("FAIL rand_retire%0d[%0d]: got v=%b tag=%0d want v=%b tag=%0d",
                             s, n, retire_valid[s], retire_tag[s], exp_rv(s), exp_rtag(s));
                    miscompares++;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors         = 0;
        miscompares     = 0;
        m_head          = 0;
        rst             = 1'b1;
        alloc_valid     = 1'b0;
        alloc_has_rd    = 1'b0;
        alloc_tag_old   = '0;
        complete_valid  = 2'b00;
        complete_idx[0] = '0;
        complete_idx[1] = '0;
        test_reset();
        test_in_order_pair();
        test_full();
        test_no_rd();
        test_wrap();
        test_dup_complete();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 64: physical tag count.
REQ-002 SHALL have parameter NUM_TAGS_LOG2, default $clog2(NUM_TAGS): tag width.
REQ-003 SHALL have parameter ROB_DEPTH, default 16 (power of two): entry count.
REQ-004 SHALL have parameter ROB_IDX_W, default $clog2(ROB_DEPTH): entry index width.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on posedge clk.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port alloc_valid, input, 1: dispatch offers one renamed instruction.
REQ-008 SHALL have port alloc_has_rd, input, 1: instruction writes a nonzero rd.
REQ-009 SHALL have port alloc_tag_old, input, NUM_TAGS_LOG2: prior tag of rd, to be freed at retire.
REQ-010 SHALL have port alloc_ready, output, 1: an entry is free this cycle.
REQ-011 SHALL have port alloc_idx, output, ROB_IDX_W: entry index given to the offered instruction.
REQ-012 SHALL have port complete_valid, input, 2: per-lane execution-complete strobe.
REQ-013 SHALL have port complete_idx, input, [0:1] x ROB_IDX_W: entry index per completion lane.
REQ-014 SHALL have port retire_tag, output, [0:1] x NUM_TAGS_LOG2: tags returned to the rename free pool.
REQ-015 SHALL have port retire_valid, output, 2: per-lane tag-free strobe.
REQ-016 SHALL have port rob_count, output, ROB_IDX_W+1: occupied entry count.
REQ-017 SHALL have port rob_empty, output, 1: high when rob_count == 0.

Function
REQ-018 SHALL be a circular buffer with head and tail pointers; each pointer has ROB_IDX_W bits plus a wrap bit, and increments modulo 2*ROB_DEPTH.
REQ-019 SHALL store per entry: valid, done, has_rd, tag_old.
REQ-020 SHALL drive alloc_ready = (rob_count < ROB_DEPTH) combinationally from registered state, independent of alloc_valid and of same-cycle retirement (no full bypass).
REQ-021 SHALL drive alloc_idx = tail[ROB_IDX_W-1:0] combinationally.
REQ-022 SHALL, when alloc_valid & alloc_ready, write entry[tail] with valid=1, done=0, has_rd, tag_old, and advance tail by 1 at the edge; alloc_valid while alloc_ready is low SHALL be ignored.
REQ-023 SHALL, per lane i with complete_valid[i], set done of entry complete_idx[i] at the edge only if that entry is valid; completions to invalid entries SHALL be ignored, and two lanes naming the same entry SHALL set done once.
REQ-024 SHALL compute retirement combinationally from registered state: slot 0 retires if entry[head] is valid and done; slot 1 retires only if slot 0 retires and entry[head+1] is valid and done.
REQ-025 SHALL drive retire_valid[i] = slot i retires & has_rd & (tag_old != 0), and retire_tag[i] = tag_old when retire_valid[i] is high, else 0.
REQ-026 SHALL clear valid and done of retired entries and advance head by 0, 1 or 2 at the edge, including entries with has_rd = 0.
REQ-027 SHALL retire in strict program order; a done entry behind an undone head SHALL NOT retire.
REQ-028 SHALL make completion visible to retirement no earlier than the cycle after complete_valid (1-cycle latency).
REQ-029 SHALL update rob_count = rob_count + accepted_alloc - retired_count each edge; simultaneous allocation and retirement SHALL be legal in every state, including full.
REQ-030 SHALL wrap both pointers at ROB_DEPTH without loss; retirement of slot 1 SHALL span the wrap from index ROB_DEPTH-1 to 0.

Reset
REQ-031 SHALL, while rst is high at the edge, set head=0, tail=0, rob_count=0, and all valid/done bits to 0, discarding any alloc or completion of that cycle.
REQ-032 SHALL, after reset, present alloc_ready=1, alloc_idx=0, rob_empty=1, retire_valid=2'b00, retire_tag={0,0}.
REQ-033 SHALL, when reset is applied mid-operation with entries pending, produce no retire_valid for any pre-reset entry.

Verification
REQ-034 SHALL cover: alloc tag_old 40 (idx 0), then 41 (idx 1); complete idx 1, then idx 0 -> retire_valid=11, retire_tag={40,41} one cycle after the idx-0 completion.
REQ-035 SHALL cover: allocate 16 entries -> alloc_ready=0, rob_count=16; a 17th alloc_valid is ignored; complete idx 0 -> next cycle retire tag of idx 0, alloc accepted the following cycle at idx 0.
REQ-036 SHALL cover: entry with has_rd=0 and entry with tag_old=0 complete -> both retire, head+2, retire_valid=00.
REQ-037 SHALL cover: head at idx 15, entries 15 and 0 done -> both retire in one cycle, head wraps to 1.
REQ-038 SHALL cover: complete_valid=11 with complete_idx={3,3}, entry 3 valid -> done set once; complete to an invalid idx -> no state change.
REQ-039 SHALL cover: rst asserted with 5 pending done entries -> next cycle rob_count=0, retire_valid=00, alloc_idx=0.
